gayle_xfer_ctrl: RTL and testbench
==================================

Name: gayle_xfer_ctrl

Overview:
Sequences IDE PIO sector transfers through the Gayle sector FIFO between the Amiga CPU data port (host side) and the drive-emulation firmware (fw side).
- Loads sector count and multiple-block size per command.
- Gates FIFO read/write strobes by phase and counts words per block.
- Drives ATA BSY/DRQ/IRQ and a firmware service request.
- Sits between the Gayle register decoder and the FIFO.

Parameters:
MAX_MULTI, 16, max sectors per DRQ block (FIFO holds 16 x 256 words)
SECTOR_WORDS, 256, 16-bit words per sector

Ports:
clk  in  1  bus clock
reset_n  in  1  asynchronous, active-low reset
clk7_en  in  1  clock enable; all state advances only when high
cmd_start  in  1  command-issue pulse from register decoder
cmd_dir  in  1  1 = drive-to-host (read), 0 = host-to-drive (write)
cmd_count  in  8  sector count; 0 means 256
cmd_multi  in  8  sectors per DRQ block; 0 means 1; clamped to MAX_MULTI
host_rd  in  1  CPU data-port read strobe
host_wr  in  1  CPU data-port write strobe
fw_rd  in  1  firmware data read strobe
fw_wr  in  1  firmware data write strobe
fw_abort  in  1  firmware aborts the command
irq_ack  in  1  host read of status register; clears irq
fifo_wr  out  1  FIFO write strobe
fifo_rd  out  1  FIFO read strobe
fifo_rst  out  1  FIFO pointer reset
bsy  out  1  ATA BSY
drq  out  1  ATA DRQ
irq  out  1  interrupt request (level)
fw_req  out  1  firmware must service the FIFO
remaining  out  9  sectors left in the command, 0..256

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE, every output 0, all counters 0.
- States: IDLE, IN_FILL, IN_DRAIN, OUT_FILL, OUT_DRAIN.
- Strobe gating (combinational, qualified by clk7_en):
  - fifo_wr = fw_wr in IN_FILL | host_wr in OUT_FILL.
  - fifo_rd = host_rd in IN_DRAIN | fw_rd in OUT_DRAIN.
  - Strobes in any other state are ignored and change no counter.
- Block size: blk = min(cmd_multi or 1, remaining, MAX_MULTI) sectors. It is recomputed on entry to each fill state. blk_words = blk*256, counted by a 13-bit word counter wcnt.
- IDLE:
  - On cmd_start: fifo_rst=1 for one enabled cycle, remaining loads cmd_count (0 gives 256), wcnt=0.
  - Next state is IN_FILL if cmd_dir=1, else OUT_FILL.
  - bsy=1 from the cmd_start cycle +1 in read; drq=1 at +1 in write.
- IN_FILL: bsy=1, fw_req=1, drq=0. Each gated fw_wr does wcnt++. When wcnt reaches blk_words: wcnt=0, go to IN_DRAIN, set irq.
- IN_DRAIN: bsy=0, drq=1, fw_req=0. Each host_rd does wcnt++. On the final word: remaining -= blk, wcnt=0, drq drops next cycle. Then IDLE if remaining==0, else IN_FILL.
- OUT_FILL: bsy=0, drq=1. Each host_wr does wcnt++. On the final word: go to OUT_DRAIN, bsy=1, drq=0. No irq on the first block.
- OUT_DRAIN: fw_req=1. Each fw_rd does wcnt++. On the final word: remaining -= blk, set irq. Then IDLE if remaining==0, else OUT_FILL.
- irq: set on the events above and on abort; cleared by irq_ack. A set and an ack in the same cycle leaves irq set.
- fw_abort (any non-IDLE state, highest priority): go to IDLE, fifo_rst pulse, bsy=0, drq=0, irq set, remaining=0.
- cmd_start outside IDLE: ignored.
- cmd_start with fw_abort in the same cycle: abort wins.
- Counters never wrap. wcnt saturates at blk_words; extra strobes after a block completes fall in a different state and are gated.
- remaining transitions 256 → 0 correctly (9-bit).
- Latency: state change and outputs update on the enabled edge after the qualifying strobe. fifo_rd/fifo_wr have zero latency.

Test Plan:
- Read, cmd_count=1, multi=0: fifo_rst pulse. fw_req/bsy until 256 fw_wr, then drq=1 and irq=1. Exactly 256 fifo_rd on host_rd. Returns to IDLE with remaining=0, bsy=0, drq=0.
- Read, cmd_count=3, multi=2: first block 512 fw_wr then 512 host_rd, remaining=1. Second block 256 words. irq set twice (acked between). Ends in IDLE.
- Write, cmd_count=0 (256), multi=16: sixteen 4096-word blocks. irq on each drain completion only. remaining steps 256, 240, ..., 0.
- fw_abort mid OUT_FILL at word 100: next edge IDLE, fifo_rst=1, drq=0, bsy=0, irq=1, remaining=0. Subsequent host_wr gives no fifo_wr.
- Strobe gating: host_rd during IN_FILL and fw_wr during IN_DRAIN produce no fifo strobes and no wcnt change. cmd_start during IN_DRAIN is ignored.
- clk7_en low for 5 cycles with strobes high: no state or counter change. Async reset_n low mid IN_DRAIN clears all outputs immediately, without a clock edge.

Source files
------------

// File: rtl/gayle_xfer_ctrl.sv
// rtl/gayle_xfer_ctrl.sv - IDE PIO sector transfer sequencer for the Gayle sector FIFO
module gayle_xfer_ctrl #(
   parameter int MAX_MULTI    = 16,
   parameter int SECTOR_WORDS = 256
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clk7_en,
   input  logic       cmd_start,
   input  logic       cmd_dir,
   input  logic [7:0] cmd_count,
   input  logic [7:0] cmd_multi,
   input  logic       host_rd,
   input  logic       host_wr,
   input  logic       fw_rd,
   input  logic       fw_wr,
   input  logic       fw_abort,
   input  logic       irq_ack,
   output logic       fifo_wr,
   output logic       fifo_rd,
   output logic       fifo_rst,
   output logic       bsy,
   output logic       drq,
   output logic       irq,
   output logic       fw_req,
   output logic [8:0] remaining
);

   typedef enum logic [2:0] {IDLE, IN_FILL, IN_DRAIN, OUT_FILL, OUT_DRAIN} state_t;

   state_t      state, state_nx;
   logic [12:0] wcnt, wcnt_nx;
   logic [8:0]  blk, blk_nx;
   logic [8:0]  multi, multi_nx;
   logic [8:0]  rem_nx, rem_after;
   logic [8:0]  count_in, multi_in;
   logic [12:0] blk_words;
   logic        irq_set, rst_nx, last, abort_hit;

   function automatic logic [8:0] min9(input logic [8:0] a, input logic [8:0] b);
      return (a < b) ? a : b;
   endfunction

   assign count_in  = (cmd_count == 8'd0) ? 9'd256 : {1'b0, cmd_count};
   assign multi_in  = (cmd_multi == 8'd0) ? 9'd1 : min9({1'b0, cmd_multi}, 9'(MAX_MULTI));
   assign blk_words = 13'(blk * SECTOR_WORDS);
   assign last      = (wcnt == blk_words - 13'd1);
   assign abort_hit = fw_abort && (state != IDLE);

   // Strobes pass straight through when the phase owns them; an abort masks them.
   assign fifo_wr = clk7_en && !abort_hit &&
                    ((state == IN_FILL && fw_wr) || (state == OUT_FILL && host_wr));
   assign fifo_rd = clk7_en && !abort_hit &&
                    ((state == IN_DRAIN && host_rd) || (state == OUT_DRAIN && fw_rd));

   assign bsy    = (state == IN_FILL) || (state == OUT_DRAIN);
   assign drq    = (state == IN_DRAIN) || (state == OUT_FILL);
   assign fw_req = (state == IN_FILL) || (state == OUT_DRAIN);

   always_comb begin
      state_nx  = state;
      wcnt_nx   = wcnt;
      rem_nx    = remaining;
      blk_nx    = blk;
      multi_nx  = multi;
      irq_set   = 1'b0;
      rst_nx    = 1'b0;
      rem_after = remaining - blk;
      case (state)
         IDLE: begin
            if (cmd_start && !fw_abort) begin
               rst_nx   = 1'b1;
               rem_nx   = count_in;
               multi_nx = multi_in;
               blk_nx   = min9(multi_in, count_in);
               wcnt_nx  = 13'd0;
               state_nx = cmd_dir ? IN_FILL : OUT_FILL;
            end
         end
         IN_FILL, OUT_FILL: begin
            if (fifo_wr) begin
               if (last) begin
                  wcnt_nx  = 13'd0;
                  state_nx = (state == IN_FILL) ? IN_DRAIN : OUT_DRAIN;
                  irq_set  = (state == IN_FILL);
               end else begin
                  wcnt_nx = wcnt + 13'd1;
               end
            end
         end
         IN_DRAIN, OUT_DRAIN: begin
            if (fifo_rd) begin
               if (last) begin
                  wcnt_nx  = 13'd0;
                  rem_nx   = rem_after;
                  blk_nx   = min9(multi, rem_after);
                  irq_set  = (state == OUT_DRAIN);
                  if (rem_after == 9'd0)
                     state_nx = IDLE;
                  else
                     state_nx = (state == IN_DRAIN) ? IN_FILL : OUT_FILL;
               end else begin
                  wcnt_nx = wcnt + 13'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
      if (abort_hit) begin
         state_nx = IDLE;
         rst_nx   = 1'b1;
         irq_set  = 1'b1;
         rem_nx   = 9'd0;
         wcnt_nx  = 13'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wcnt      <= 13'd0;
         blk       <= 9'd0;
         multi     <= 9'd0;
         remaining <= 9'd0;
         irq       <= 1'b0;
         fifo_rst  <= 1'b0;
      end else if (clk7_en) begin
         state     <= state_nx;
         wcnt      <= wcnt_nx;
         blk       <= blk_nx;
         multi     <= multi_nx;
         remaining <= rem_nx;
         // A set in the same cycle as an ack wins.
         irq       <= irq_set || (irq && !irq_ack);
         fifo_rst  <= rst_nx;
      end
   end

endmodule

// File: tb/tb_gayle_xfer_ctrl.sv
// tb/tb_gayle_xfer_ctrl.sv - directed self-checking bench for gayle_xfer_ctrl
module tb_gayle_xfer_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       clk7_en = 1'b1;
   logic       cmd_start = 1'b0;
   logic       cmd_dir = 1'b0;
   logic [7:0] cmd_count = 8'd0;
   logic [7:0] cmd_multi = 8'd0;
   logic       host_rd = 1'b0;
   logic       host_wr = 1'b0;
   logic       fw_rd = 1'b0;
   logic       fw_wr = 1'b0;
   logic       fw_abort = 1'b0;
   logic       irq_ack = 1'b0;
   logic       fifo_wr, fifo_rd, fifo_rst, bsy, drq, irq, fw_req;
   logic [8:0] remaining;

   int checks = 0;
   int errors = 0;
   int got;

   localparam int S_FW_WR = 0, S_HOST_RD = 1, S_HOST_WR = 2, S_FW_RD = 3;

   gayle_xfer_ctrl dut (
      .clk(clk), .reset_n(reset_n), .clk7_en(clk7_en),
      .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_multi(cmd_multi),
      .host_rd(host_rd), .host_wr(host_wr), .fw_rd(fw_rd), .fw_wr(fw_wr),
      .fw_abort(fw_abort), .irq_ack(irq_ack),
      .fifo_wr(fifo_wr), .fifo_rd(fifo_rd), .fifo_rst(fifo_rst),
      .bsy(bsy), .drq(drq), .irq(irq), .fw_req(fw_req), .remaining(remaining)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic set_strobe(input int which, input logic v);
      case (which)
         S_FW_WR:   fw_wr   = v;
         S_HOST_RD: host_rd = v;
         S_HOST_WR: host_wr = v;
         default:   fw_rd   = v;
      endcase
   endtask

   // Holds one strobe for n cycles and counts the FIFO strobes it produced.
   task automatic xfer(input int which, input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         set_strobe(which, 1'b1);
         #1;
         if (which == S_FW_WR || which == S_HOST_WR)
            cnt += fifo_wr ? 1 : 0;
         else
            cnt += fifo_rd ? 1 : 0;
      end
      @(negedge clk);
      set_strobe(which, 1'b0);
      #1;
   endtask

   task automatic start_cmd(input logic dir, input logic [7:0] cnt, input logic [7:0] mul);
      @(negedge clk);
      cmd_start = 1'b1; cmd_dir = dir; cmd_count = cnt; cmd_multi = mul;
      @(negedge clk);
      cmd_start = 1'b0;
      #1;
   endtask

   task automatic pulse_ack();
      @(negedge clk);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      #1;
   endtask

   initial begin
      #1;
      check("rst_bsy", bsy, 0);
      check("rst_drq", drq, 0);
      check("rst_irq", irq, 0);
      check("rst_fwreq", fw_req, 0);
      check("rst_fiforst", fifo_rst, 0);
      check("rst_remaining", remaining, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // single-sector read
      start_cmd(1'b1, 8'd1, 8'd0);
      check("r1_fiforst", fifo_rst, 1);
      check("r1_bsy", bsy, 1);
      check("r1_fwreq", fw_req, 1);
      check("r1_drq", drq, 0);
      check("r1_remaining", remaining, 1);
      @(negedge clk); #1;
      check("r1_fiforst_drop", fifo_rst, 0);
      xfer(S_FW_WR, 256, got);
      check("r1_fill_wr", got, 256);
      check("r1_drain_drq", drq, 1);
      check("r1_drain_bsy", bsy, 0);
      check("r1_irq", irq, 1);
      pulse_ack();
      check("r1_irq_ack", irq, 0);
      xfer(S_FW_WR, 3, got);
      check("r1_gate_fwwr", got, 0);
      xfer(S_HOST_RD, 256, got);
      check("r1_drain_rd", got, 256);
      check("r1_end_bsy", bsy, 0);
      check("r1_end_drq", drq, 0);
      check("r1_end_remaining", remaining, 0);

      // three-sector read, two sectors per block
      start_cmd(1'b1, 8'd3, 8'd2);
      xfer(S_HOST_RD, 5, got);
      check("r3_gate_hostrd", got, 0);
      xfer(S_FW_WR, 511, got);
      check("r3_fill_511", got, 511);
      check("r3_still_fill", drq, 0);
      xfer(S_FW_WR, 1, got);
      check("r3_blk1_drq", drq, 1);
      check("r3_blk1_irq", irq, 1);
      start_cmd(1'b0, 8'd9, 8'd0);
      check("r3_ign_start_drq", drq, 1);
      check("r3_ign_start_rst", fifo_rst, 0);
      check("r3_ign_start_rem", remaining, 3);
      pulse_ack();
      xfer(S_HOST_RD, 512, got);
      check("r3_blk1_rd", got, 512);
      check("r3_rem1", remaining, 1);
      check("r3_back_fill", bsy, 1);
      check("r3_irq_clear", irq, 0);
      xfer(S_FW_WR, 256, got);
      check("r3_blk2_wr", got, 256);
      check("r3_blk2_drq", drq, 1);
      check("r3_blk2_irq", irq, 1);
      pulse_ack();
      xfer(S_HOST_RD, 256, got);
      check("r3_end_rem", remaining, 0);
      check("r3_end_drq", drq, 0);

      // 256-sector write, sixteen sectors per block, first two blocks then abort
      start_cmd(1'b0, 8'd0, 8'd16);
      check("w_fiforst", fifo_rst, 1);
      check("w_drq", drq, 1);
      check("w_bsy", bsy, 0);
      check("w_rem256", remaining, 256);
      xfer(S_HOST_WR, 4096, got);
      check("w_blk1_wr", got, 4096);
      check("w_blk1_bsy", bsy, 1);
      check("w_blk1_fwreq", fw_req, 1);
      check("w_blk1_noirq", irq, 0);
      xfer(S_FW_RD, 4096, got);
      check("w_blk1_rd", got, 4096);
      check("w_blk1_irq", irq, 1);
      check("w_rem240", remaining, 240);
      check("w_refill_drq", drq, 1);
      pulse_ack();
      xfer(S_HOST_WR, 4096, got);
      xfer(S_FW_RD, 4096, got);
      check("w_rem224", remaining, 224);
      check("w_blk2_irq", irq, 1);
      pulse_ack();
      xfer(S_HOST_WR, 100, got);
      check("ab_pre_wr", got, 100);
      @(negedge clk);
      fw_abort = 1'b1;
      @(negedge clk);
      fw_abort = 1'b0;
      #1;
      check("ab_fiforst", fifo_rst, 1);
      check("ab_drq", drq, 0);
      check("ab_bsy", bsy, 0);
      check("ab_irq", irq, 1);
      check("ab_rem", remaining, 0);
      xfer(S_HOST_WR, 5, got);
      check("ab_gate_wr", got, 0);
      pulse_ack();

      // clock enable low freezes everything
      start_cmd(1'b1, 8'd1, 8'd0);
      xfer(S_FW_WR, 10, got);
      @(negedge clk);
      clk7_en = 1'b0;
      xfer(S_FW_WR, 5, got);
      check("ce_gate_wr", got, 0);
      check("ce_hold_bsy", bsy, 1);
      clk7_en = 1'b1;
      xfer(S_FW_WR, 246, got);
      check("ce_resume_wr", got, 246);
      check("ce_drain_drq", drq, 1);
      check("ce_irq", irq, 1);

      // asynchronous reset mid IN_DRAIN, before the next clock edge
      xfer(S_HOST_RD, 50, got);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("ar_drq", drq, 0);
      check("ar_bsy", bsy, 0);
      check("ar_irq", irq, 0);
      check("ar_rem", remaining, 0);
      check("ar_fwreq", fw_req, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
